// File: rtl/pwm_pkg.sv
// Shared constants and types for the multi-channel PWM block.
package pwm_pkg;

  localparam int unsigned ADDR_CTRL   = 0;
  localparam int unsigned ADDR_PERIOD = 1;
  localparam int unsigned ADDR_POL    = 2;
  localparam int unsigned ADDR_DUTY0  = 3;

  localparam int unsigned CTRL_EN   = 0;
  localparam int unsigned CTRL_MODE = 1;

  typedef enum logic {
    PWM_EDGE   = 1'b0,
    PWM_CENTER = 1'b1
  } pwm_mode_e;

endpackage

// File: rtl/pwm_multi_if.sv
// Register write port of pwm_multi: bridge side is master, PWM block is slave.
interface pwm_multi_if #(
  parameter int unsigned W   = 16,
  parameter int unsigned NCH = 4
) ();

  localparam int unsigned AW = $clog2(NCH + 3);

  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [W-1:0]  wr_data;

  modport master (output wr_en, wr_addr, wr_data);
  modport slave  (input  wr_en, wr_addr, wr_data);

endinterface

// File: rtl/pwm_timebase.sv
// Shared PWM counter: edge (sawtooth) or center (triangle, endpoints held twice).
module pwm_timebase
  import pwm_pkg::*;
#(
  parameter int unsigned W = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           en,
  input  pwm_mode_e      mode_act,
  input  logic [W-1:0]   period_act,
  output logic [W-1:0]   cnt_next,
  output logic           boundary
);

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  logic [W-1:0] cnt_q, cnt_d;
  dir_e         dir_q, dir_d;
  logic [W-1:0] last_cnt;
  logic         at_top;

  // A zero period is treated as a one-cycle period.
  assign last_cnt = (period_act == '0) ? '0 : period_act - W'(1);
  assign at_top   = (cnt_q >= last_cnt);

  always_comb begin
    cnt_d    = cnt_q;
    dir_d    = dir_q;
    boundary = 1'b0;
    if (!en) begin
      cnt_d = '0;
      dir_d = DIR_UP;
    end else if (mode_act == PWM_EDGE) begin
      if (at_top) begin
        boundary = 1'b1;
        cnt_d    = '0;
        dir_d    = DIR_UP;
      end else begin
        cnt_d = cnt_q + W'(1);
      end
    end else if (dir_q == DIR_UP) begin
      if (at_top) begin
        dir_d = DIR_DOWN;
      end else begin
        cnt_d = cnt_q + W'(1);
      end
    end else if (cnt_q == '0) begin
      boundary = 1'b1;
      dir_d    = DIR_UP;
    end else begin
      cnt_d = cnt_q - W'(1);
    end
  end

  assign cnt_next = cnt_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      dir_q <= DIR_UP;
    end else begin
      cnt_q <= cnt_d;
      dir_q <= dir_d;
    end
  end

endmodule

// File: rtl/pwm_multi.sv
// NCH-channel PWM on one shared timebase; shadowed settings go live at period boundaries.
module pwm_multi
  import pwm_pkg::*;
#(
  parameter int unsigned W   = 16,
  parameter int unsigned NCH = 4
) (
  input  logic              clk,
  input  logic              rst,
  pwm_multi_if.slave        wr,
  output logic [NCH-1:0]    pwm_out,
  output logic              period_end
);

  localparam int unsigned AW = $clog2(NCH + 3);

  logic           en_q, en_d;
  pwm_mode_e      mode_sh_q, mode_sh_d, mode_act_q, mode_act_d;
  logic [W-1:0]   per_sh_q, per_sh_d, per_act_q, per_act_d;
  logic [NCH-1:0] pol_sh_q, pol_sh_d, pol_act_q, pol_act_d;
  logic [NCH-1:0] pwm_d;
  logic           pe_d;
  logic           run;
  logic           boundary;
  logic [W-1:0]   cnt_next;

  always_comb begin
    en_d      = en_q;
    mode_sh_d = mode_sh_q;
    per_sh_d  = per_sh_q;
    pol_sh_d  = pol_sh_q;
    if (wr.wr_en) begin
      case (wr.wr_addr)
        AW'(ADDR_CTRL): begin
          en_d      = wr.wr_data[CTRL_EN];
          mode_sh_d = pwm_mode_e'(wr.wr_data[CTRL_MODE]);
        end
        AW'(ADDR_PERIOD): per_sh_d = wr.wr_data;
        AW'(ADDR_POL):    pol_sh_d = wr.wr_data[NCH-1:0];
        default: ;
      endcase
    end
  end

  // Running only when enabled both before and after this edge; the enabling
  // and disabling edges park the counter at zero.
  assign run = en_q & en_d;

  // While not running, active follows shadow including this edge's write;
  // at a boundary it takes the pre-write shadow so late writes wait a period.
  always_comb begin
    mode_act_d = mode_act_q;
    per_act_d  = per_act_q;
    pol_act_d  = pol_act_q;
    if (!run) begin
      mode_act_d = mode_sh_d;
      per_act_d  = per_sh_d;
      pol_act_d  = pol_sh_d;
    end else if (boundary) begin
      mode_act_d = mode_sh_q;
      per_act_d  = per_sh_q;
      pol_act_d  = pol_sh_q;
    end
  end

  pwm_timebase #(.W(W)) u_timebase (
    .clk        (clk),
    .rst        (rst),
    .en         (run),
    .mode_act   (mode_act_q),
    .period_act (per_act_q),
    .cnt_next   (cnt_next),
    .boundary   (boundary)
  );

  assign pe_d = en_d & (~en_q | boundary);

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic [W-1:0] duty_sh_q, duty_sh_d, duty_act_q, duty_act_d;

    assign duty_sh_d  = (wr.wr_en && wr.wr_addr == AW'(ADDR_DUTY0 + i)) ? wr.wr_data : duty_sh_q;
    assign duty_act_d = !run ? duty_sh_d : (boundary ? duty_sh_q : duty_act_q);
    assign pwm_d[i]   = en_d ? ((cnt_next < duty_act_d) ^ pol_act_d[i]) : pol_sh_d[i];

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        duty_sh_q  <= '0;
        duty_act_q <= '0;
      end else begin
        duty_sh_q  <= duty_sh_d;
        duty_act_q <= duty_act_d;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en_q       <= 1'b0;
      mode_sh_q  <= PWM_EDGE;
      mode_act_q <= PWM_EDGE;
      per_sh_q   <= '0;
      per_act_q  <= '0;
      pol_sh_q   <= '0;
      pol_act_q  <= '0;
      pwm_out    <= '0;
      period_end <= 1'b0;
    end else begin
      en_q       <= en_d;
      mode_sh_q  <= mode_sh_d;
      mode_act_q <= mode_act_d;
      per_sh_q   <= per_sh_d;
      per_act_q  <= per_act_d;
      pol_sh_q   <= pol_sh_d;
      pol_act_q  <= pol_act_d;
      pwm_out    <= pwm_d;
      period_end <= pe_d;
    end
  end

endmodule

// File: tb/tb_pwm_multi.sv
// Directed bench for pwm_multi with W = 8, NCH = 4; outputs sampled on the falling edge.
module tb_pwm_multi;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] pwm_out;
  logic       period_end;
  int         n_checks = 0;
  int         n_fail   = 0;

  pwm_multi_if #(.W(8), .NCH(4)) bus ();

  pwm_multi #(.W(8), .NCH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .wr         (bus),
    .pwm_out    (pwm_out),
    .period_end (period_end)
  );

  always #5 clk = ~clk;

  // Drive one write during the current cycle; returns in the following cycle.
  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    bus.wr_en   = 1'b1;
    bus.wr_addr = a;
    bus.wr_data = d;
    @(negedge clk);
    bus.wr_en   = 1'b0;
  endtask

  task automatic wait_pe(input string tag);
    int k = 0;
    while (period_end !== 1'b1 && k < 50) begin
      @(negedge clk);
      k++;
    end
    n_checks++;
    if (period_end !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_sync: period_end got %b want 1", tag, period_end);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_checks++;
    if (pwm_out !== 4'b0000) begin n_fail++; $display("FAIL reset_pwm: got %b want 0000", pwm_out); end
    n_checks++;
    if (period_end !== 1'b0) begin n_fail++; $display("FAIL reset_pe: got %b want 0", period_end); end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if (pwm_out !== 4'b0000 || period_end !== 1'b0) begin
      n_fail++; $display("FAIL reset_idle: got %b/%b want 0000/0", pwm_out, period_end);
    end
  endtask

  task automatic test_edge();
    logic [3:0] e;
    wr(1, 8'd10);
    wr(3, 8'd3);
    wr(4, 8'd10);
    n_checks++;
    if (pwm_out !== 4'b0000) begin n_fail++; $display("FAIL edge_idle: got %b want 0000", pwm_out); end
    wr(0, 8'h01);
    for (int k = 0; k < 30; k++) begin
      e = {2'b00, 1'b1, ((k % 10) < 3)};
      n_checks++;
      if (pwm_out !== e) begin n_fail++; $display("FAIL edge_pwm k=%0d: got %b want %b", k, pwm_out, e); end
      n_checks++;
      if (period_end !== (k % 10 == 0)) begin
        n_fail++; $display("FAIL edge_pe k=%0d: got %b want %b", k, period_end, (k % 10 == 0));
      end
      @(negedge clk);
    end
  endtask

  task automatic test_shadow();
    logic [3:0] e;
    wait_pe("shadow");
    repeat (5) @(negedge clk);
    wr(3, 8'd7);
    for (int k = 6; k < 20; k++) begin
      e = {2'b00, 1'b1, ((k % 10) < ((k < 10) ? 3 : 7))};
      n_checks++;
      if (pwm_out !== e) begin n_fail++; $display("FAIL shadow_pwm k=%0d: got %b want %b", k, pwm_out, e); end
      n_checks++;
      if (period_end !== (k == 10)) begin
        n_fail++; $display("FAIL shadow_pe k=%0d: got %b want %b", k, period_end, (k == 10));
      end
      @(negedge clk);
    end
  endtask

  task automatic test_boundary_write();
    logic [3:0] e;
    wait_pe("bwrite");
    repeat (9) @(negedge clk);
    wr(3, 8'd2);
    for (int k = 0; k < 20; k++) begin
      e = {2'b00, 1'b1, ((k % 10) < ((k < 10) ? 7 : 2))};
      n_checks++;
      if (pwm_out !== e) begin n_fail++; $display("FAIL bwrite_pwm k=%0d: got %b want %b", k, pwm_out, e); end
      n_checks++;
      if (period_end !== (k % 10 == 0)) begin
        n_fail++; $display("FAIL bwrite_pe k=%0d: got %b want %b", k, period_end, (k % 10 == 0));
      end
      @(negedge clk);
    end
  endtask

  task automatic test_clear_en();
    wait_pe("clear");
    repeat (4) @(negedge clk);
    wr(0, 8'h00);
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if (pwm_out !== 4'b0000 || period_end !== 1'b0) begin
        n_fail++; $display("FAIL clear_en k=%0d: got %b/%b want 0000/0", k, pwm_out, period_end);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_polarity();
    logic [3:0] e;
    wr(2, 8'h01);
    n_checks++;
    if (pwm_out !== 4'b0001) begin n_fail++; $display("FAIL pol_idle: got %b want 0001", pwm_out); end
    wr(3, 8'd3);
    wr(0, 8'h01);
    for (int k = 0; k < 20; k++) begin
      e = {2'b00, 1'b1, !((k % 10) < 3)};
      n_checks++;
      if (pwm_out !== e) begin n_fail++; $display("FAIL pol_pwm k=%0d: got %b want %b", k, pwm_out, e); end
      n_checks++;
      if (period_end !== (k % 10 == 0)) begin
        n_fail++; $display("FAIL pol_pe k=%0d: got %b want %b", k, period_end, (k % 10 == 0));
      end
      @(negedge clk);
    end
    wr(0, 8'h00);
    n_checks++;
    if (pwm_out !== 4'b0001 || period_end !== 1'b0) begin
      n_fail++; $display("FAIL pol_disable: got %b/%b want 0001/0", pwm_out, period_end);
    end
  endtask

  task automatic test_center();
    logic [3:0] e;
    wr(2, 8'h00);
    wr(4, 8'd0);
    wr(3, 8'd1);
    wr(1, 8'd4);
    wr(0, 8'h02);
    n_checks++;
    if (pwm_out !== 4'b0000) begin n_fail++; $display("FAIL center_idle: got %b want 0000", pwm_out); end
    wr(0, 8'h03);
    for (int k = 0; k < 24; k++) begin
      e = {3'b000, ((k % 8 == 0) || (k % 8 == 7))};
      n_checks++;
      if (pwm_out !== e) begin n_fail++; $display("FAIL center_pwm k=%0d: got %b want %b", k, pwm_out, e); end
      n_checks++;
      if (period_end !== (k % 8 == 0)) begin
        n_fail++; $display("FAIL center_pe k=%0d: got %b want %b", k, period_end, (k % 8 == 0));
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset_midrun();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    n_checks++;
    if (pwm_out !== 4'b0000 || period_end !== 1'b0) begin
      n_fail++; $display("FAIL rst_async: got %b/%b want 0000/0", pwm_out, period_end);
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      n_checks++;
      if (pwm_out !== 4'b0000 || period_end !== 1'b0) begin
        n_fail++; $display("FAIL rst_quiet k=%0d: got %b/%b want 0000/0", k, pwm_out, period_end);
      end
    end
    // Enabling with every register at its reset value: N=0 period, duty 0.
    wr(0, 8'h01);
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if (pwm_out !== 4'b0000 || period_end !== 1'b1) begin
        n_fail++; $display("FAIL rst_defaults k=%0d: got %b/%b want 0000/1", k, pwm_out, period_end);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_period_zero();
    wr(0, 8'h00);
    wr(3, 8'd1);
    wr(1, 8'd0);
    wr(0, 8'h01);
    for (int k = 0; k < 8; k++) begin
      n_checks++;
      if (pwm_out !== 4'b0001 || period_end !== 1'b1) begin
        n_fail++; $display("FAIL n0 k=%0d: got %b/%b want 0001/1", k, pwm_out, period_end);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_bad_addr();
    wr(7, 8'hFF);
    for (int k = 0; k < 6; k++) begin
      n_checks++;
      if (pwm_out !== 4'b0001 || period_end !== 1'b1) begin
        n_fail++; $display("FAIL addr7 k=%0d: got %b/%b want 0001/1", k, pwm_out, period_end);
      end
      @(negedge clk);
    end
    wr(0, 8'h00);
    n_checks++;
    if (pwm_out !== 4'b0000 || period_end !== 1'b0) begin
      n_fail++; $display("FAIL addr7_idle: got %b/%b want 0000/0", pwm_out, period_end);
    end
  endtask

  initial begin
    rst         = 1'b1;
    bus.wr_en   = 1'b0;
    bus.wr_addr = '0;
    bus.wr_data = '0;
    test_reset();
    test_edge();
    test_shadow();
    test_boundary_write();
    test_clear_en();
    test_polarity();
    test_center();
    test_reset_midrun();
    test_period_zero();
    test_bad_addr();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
